// File: rtl/rsa_spi_regbank.sv
// SPI register bank for the RSA core: operand bytes, command pulses, busy/done/error tracking.
// spireg is the serial slave: frame = command byte {wr, .., addr} then one data byte, MSB first, SPI mode 0.

module spireg #(
   parameter int REG_W      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  spi_cs_n,
   input  logic                  spi_clk,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic [REG_W-1:0]      reg_data_o,
   output logic                  reg_data_o_vld,
   input  logic [REG_W-1:0]      reg_data_i
);
   localparam int CW = $clog2(2*REG_W) + 1;

   logic [1:0]            cs_q;
   logic [2:0]            sclk_q;
   logic [1:0]            mosi_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [REG_W-1:0]      rx_q, rx_d, tx_q, tx_d, data_q, data_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d, vld_q, vld_d, load_q, load_d;
   logic                  rise_s;
   logic [REG_W-1:0]      byte_s;

   // Pin synchronisers; mosi shares the sclk pipeline depth so data lines up with the edge
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cs_q   <= 2'b11;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         cs_q   <= {cs_q[0], spi_cs_n};
         sclk_q <= {sclk_q[1:0], spi_clk};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   assign rise_s = sclk_q[1] & ~sclk_q[2];
   assign byte_s = {rx_q[REG_W-2:0], mosi_q[1]};

   // Bit counting, shifting, address capture and write-commit pulse
   always_comb begin
      cnt_d  = cnt_q;
      rx_d   = rx_q;
      tx_d   = tx_q;
      data_d = data_q;
      addr_d = addr_q;
      wr_d   = wr_q;
      vld_d  = 1'b0;
      load_d = 1'b0;
      if (cs_q[1]) begin
         cnt_d = '0;
      end else begin
         if (load_q) begin
            tx_d = reg_data_i;
         end else begin
            tx_d = tx_q;
         end
         if (rise_s && (cnt_q != CW'(2*REG_W))) begin
            rx_d  = byte_s;
            tx_d  = {tx_q[REG_W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(REG_W-1)) begin
               wr_d   = byte_s[REG_W-1];
               addr_d = byte_s[ADDR_WIDTH-1:0];
               load_d = ~byte_s[REG_W-1];
            end else if (cnt_q == CW'(2*REG_W-1)) begin
               data_d = byte_s;
               vld_d  = wr_q;
            end else begin
               vld_d = 1'b0;
            end
         end else begin
            vld_d = 1'b0;
         end
      end
   end

   // Slave state registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q  <= '0;
         rx_q   <= '0;
         tx_q   <= '0;
         data_q <= '0;
         addr_q <= '0;
         wr_q   <= 1'b0;
         vld_q  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rx_q   <= rx_d;
         tx_q   <= tx_d;
         data_q <= data_d;
         addr_q <= addr_d;
         wr_q   <= wr_d;
         vld_q  <= vld_d;
         load_q <= load_d;
      end
   end

   assign spi_miso       = tx_q[REG_W-1];
   assign reg_addr_o     = addr_q;
   assign reg_data_o     = data_q;
   assign reg_data_o_vld = vld_q;
endmodule

module rsa_spi_regbank #(
   parameter int REG_W      = 8,
   parameter int OPW        = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             spi_cs_n,
   input  logic             spi_clk,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_start_cmd,
   output logic             spi_stop_cmd,
   output logic [OPW-1:0]   rsa_p,
   output logic [OPW-1:0]   rsa_e,
   output logic [OPW-1:0]   rsa_m,
   output logic [OPW-1:0]   rsa_const,
   input  logic [OPW-1:0]   rsa_c,
   input  logic             eoc,
   output logic             irq,
   output logic [REG_W-1:0] spare
);
   localparam int NB      = OPW / REG_W;
   localparam int NOP     = 4 * NB;
   localparam int C_BASE  = 2 + NOP;
   localparam int SPARE_A = 2 + 5*NB;

   logic [ADDR_WIDTH-1:0] addr_s;
   logic [REG_W-1:0]      wdata_s, rdata_s;
   logic                  vld_s;
   logic [REG_W-1:0]      op_q [NOP];
   logic [REG_W-1:0]      op_d [NOP];
   logic [OPW-1:0]        c_q, c_d;
   logic [REG_W-1:0]      spare_q, spare_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
   logic                  start_q, start_d, stop_q, stop_d;
   logic                  wr_s, is_ctrl_s, is_op_s, is_spare_s, eoc_hit_s;
   logic                  start_s, stop_s, clr_s, err_s;

   spireg #(.REG_W(REG_W), .ADDR_WIDTH(ADDR_WIDTH)) u_spireg (
      .clk(clk), .rstb(rstb), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .reg_addr_o(addr_s), .reg_data_o(wdata_s),
      .reg_data_o_vld(vld_s), .reg_data_i(rdata_s)
   );

   // Write decode; stop in the same CTRL write masks start
   always_comb begin
      wr_s       = vld_s & ena;
      is_ctrl_s  = (addr_s == ADDR_WIDTH'(1));
      is_op_s    = (addr_s >= ADDR_WIDTH'(2)) && (addr_s < ADDR_WIDTH'(C_BASE));
      is_spare_s = (addr_s == ADDR_WIDTH'(SPARE_A));
      eoc_hit_s  = ena & eoc & busy_q;
      stop_s     = wr_s & is_ctrl_s & wdata_s[1];
      start_s    = wr_s & is_ctrl_s & wdata_s[0] & ~wdata_s[1];
      clr_s      = wr_s & is_ctrl_s & wdata_s[2];
      err_s      = (start_s & busy_q) | (wr_s & is_op_s & busy_q)
                 | (wr_s & ~is_ctrl_s & ~is_op_s & ~is_spare_s);
   end

   // Next state: clears are applied before sets so a coincident set wins
   always_comb begin
      op_d     = op_q;
      c_d      = c_q;
      spare_d  = spare_q;
      irq_en_d = irq_en_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      if (wr_s && is_ctrl_s) begin
         irq_en_d = wdata_s[3];
      end else begin
         irq_en_d = irq_en_q;
      end
      if (wr_s && is_spare_s) begin
         spare_d = wdata_s;
      end else begin
         spare_d = spare_q;
      end
      for (int k = 0; k < NOP; k++) begin
         if (wr_s && !busy_q && (addr_s == ADDR_WIDTH'(2 + k))) begin
            op_d[k] = wdata_s;
         end else begin
            op_d[k] = op_q[k];
         end
      end
      if (clr_s) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end else begin
         done_d = done_q;
      end
      if (stop_s) begin
         stop_d = 1'b1;
         busy_d = 1'b0;
      end else if (start_s && !busy_q) begin
         start_d = 1'b1;
         busy_d  = 1'b1;
         done_d  = 1'b0;
      end else begin
         start_d = 1'b0;
      end
      if (eoc_hit_s) begin
         c_d    = rsa_c;
         busy_d = 1'b0;
         done_d = 1'b1;
      end else begin
         c_d = c_q;
      end
      if (err_s) begin
         err_d = 1'b1;
      end else begin
         stop_d = stop_d;
      end
   end

   // Bank state and command pulse registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         op_q     <= '{default: '0};
         c_q      <= '0;
         spare_q  <= '0;
         irq_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         op_q     <= op_d;
         c_q      <= c_d;
         spare_q  <= spare_d;
         irq_en_q <= irq_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
      end
   end

   // Read mux over the address map; unmapped addresses read zero
   always_comb begin
      rdata_s = '0;
      if (addr_s == ADDR_WIDTH'(0)) begin
         rdata_s[2:0] = {err_q, done_q, busy_q};
      end else if (is_ctrl_s) begin
         rdata_s[3] = irq_en_q;
      end else if (is_spare_s) begin
         rdata_s = spare_q;
      end else begin
         for (int k = 0; k < NOP; k++) begin
            if (addr_s == ADDR_WIDTH'(2 + k)) rdata_s = op_q[k];
            else rdata_s = rdata_s;
         end
         for (int k = 0; k < NB; k++) begin
            if (addr_s == ADDR_WIDTH'(C_BASE + k)) rdata_s = c_q[k*REG_W +: REG_W];
            else rdata_s = rdata_s;
         end
      end
   end

   for (genvar g = 0; g < NB; g++) begin : g_ops
      assign rsa_p[g*REG_W +: REG_W]     = op_q[g];
      assign rsa_e[g*REG_W +: REG_W]     = op_q[NB + g];
      assign rsa_m[g*REG_W +: REG_W]     = op_q[2*NB + g];
      assign rsa_const[g*REG_W +: REG_W] = op_q[3*NB + g];
   end

   assign spi_start_cmd = start_q;
   assign spi_stop_cmd  = stop_q;
   assign spare         = spare_q;
   assign irq           = done_q & irq_en_q;
endmodule
